score_tally: RTL and testbench

SCORE_TALLY -- requirements
Module: score_tally

---
 rtl/score_tally.sv | 194 +++++++++++++++++++
 tb/tb_score_tally.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_tally.sv
// rtl/score_tally.sv - per-frame hit scoring with combo tracking and a timed game FSM
// Optional SCORE_TALLY_BCD_EN adds a registered four-digit BCD copy of score (score_bcd).
module score_tally #(
  parameter int N_DROP       = 8,
  parameter int COMBO_WINDOW = 120,
  parameter int GAME_LEN     = 3600,
  parameter int SCORE_MAX    = 9999
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic [N_DROP-1:0] hit_in,
  output logic [13:0]       score,
  output logic [7:0]        combo,
  output logic [7:0]        max_combo,
  output logic              hit_pulse,
`ifdef SCORE_TALLY_BCD_EN
  output logic [15:0]       score_bcd,
`endif
  output logic              game_over
);

  localparam int KW = $clog2(N_DROP + 1);
  localparam int FW = $clog2(GAME_LEN + 1);
  localparam int IW = $clog2(COMBO_WINDOW + 1);

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_RESET = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [N_DROP-1:0] hit_q;
  logic [FW-1:0]     frame_cnt;
  logic [IW-1:0]     idle_cnt;

  logic [N_DROP-1:0] new_hits;
  logic [KW-1:0]     k;
  logic              bonus;
  logic [9:0]        combo_sum;
  logic [7:0]        combo_next;
  logic [15:0]       add_val;
  logic [16:0]       score_sum;
  logic [13:0]       score_next;
  logic [7:0]        max_next;

  always_comb begin
    new_hits = hit_in & ~hit_q;
    k = '0;
    for (int i = 0; i < N_DROP; i++) begin
      k = k + KW'(new_hits[i]);
    end
  end

  // Bonus is decided on the combo value before this frame's hits are added.
  always_comb begin
    bonus      = (combo >= 8'd10);
    combo_sum  = 10'(combo) + 10'(k);
    combo_next = (combo_sum > 10'd255) ? 8'd255 : combo_sum[7:0];
    add_val    = 16'(k) * 16'd10;
    if (bonus) begin
      add_val = add_val << 1;
    end
    score_sum  = 17'(score) + 17'(add_val);
    score_next = (score_sum > 17'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
    max_next   = (combo_next > max_combo) ? combo_next : max_combo;
  end

`ifdef SCORE_TALLY_BCD_EN
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [15:0] MAX_BCD = to_bcd(SCORE_MAX);

  logic [7:0]  mult;
  logic [11:0] mult_bcd;
  logic [15:0] add_bcd;
  logic [15:0] bcd_sum;
  logic [15:0] bcd_next;
  logic [4:0]  dsum;
  logic        dcarry;

  // The addend is always 10*mult, so only mult needs converting; a shift-add
  // conversion of that small value keeps the datapath free of dividers.
  always_comb begin
    mult     = bonus ? (8'(k) << 1) : 8'(k);
    mult_bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      for (int d = 0; d < 3; d++) begin
        if (mult_bcd[4*d +: 4] >= 4'd5) begin
          mult_bcd[4*d +: 4] = mult_bcd[4*d +: 4] + 4'd3;
        end
      end
      mult_bcd = {mult_bcd[10:0], mult[i]};
    end
    add_bcd = {mult_bcd, 4'h0};

    dcarry  = 1'b0;
    bcd_sum = '0;
    dsum    = '0;
    for (int d = 0; d < 4; d++) begin
      dsum = 5'(score_bcd[4*d +: 4]) + 5'(add_bcd[4*d +: 4]) + 5'(dcarry);
      if (dsum > 5'd9) begin
        bcd_sum[4*d +: 4] = 4'(dsum - 5'd10);
        dcarry            = 1'b1;
      end else begin
        bcd_sum[4*d +: 4] = dsum[3:0];
        dcarry            = 1'b0;
      end
    end
    bcd_next = (score_sum > 17'(SCORE_MAX)) ? MAX_BCD : bcd_sum;
  end
`endif

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      hit_q     <= '0;
      frame_cnt <= '0;
      idle_cnt  <= '0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
`ifdef SCORE_TALLY_BCD_EN
      score_bcd <= '0;
`endif
    end else begin
      hit_q     <= hit_in;
      hit_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (keycode == KEY_START) begin
            state     <= S_PLAY;
            hit_q     <= '0;
            frame_cnt <= '0;
            idle_cnt  <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
`ifdef SCORE_TALLY_BCD_EN
            score_bcd <= '0;
`endif
          end
        end
        S_PLAY: begin
          if (k != '0) begin
            score     <= score_next;
            combo     <= combo_next;
            max_combo <= max_next;
            idle_cnt  <= '0;
            hit_pulse <= 1'b1;
`ifdef SCORE_TALLY_BCD_EN
            score_bcd <= bcd_next;
`endif
          end else if (idle_cnt == IW'(COMBO_WINDOW - 1)) begin
            combo    <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (frame_cnt == FW'(GAME_LEN - 1)) begin
            state     <= S_DONE;
            game_over <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (keycode == KEY_RESET) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_tally.sv
// tb/tb_score_tally.sv - self-checking bench for score_tally against a frame-level game model
module tb_score_tally;

  localparam int ND   = 8;
  localparam int CW   = 120;
  localparam int GL   = 3600;
  localparam int SMAX = 9999;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [ND-1:0] hit_in;
  logic [13:0]   score;
  logic [7:0]    combo;
  logic [7:0]    max_combo;
  logic          hit_pulse;
  logic          game_over;
`ifdef SCORE_TALLY_BCD_EN
  logic [15:0]   score_bcd;
`endif

  int checks   = 0;
  int failures = 0;

  score_tally #(.N_DROP(ND), .COMBO_WINDOW(CW), .GAME_LEN(GL), .SCORE_MAX(SMAX)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .hit_in    (hit_in),
    .score     (score),
    .combo     (combo),
    .max_combo (max_combo),
    .hit_pulse (hit_pulse),
`ifdef SCORE_TALLY_BCD_EN
    .score_bcd (score_bcd),
`endif
    .game_over (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: 0 idle, 1 playing, 2 finished.
  int m_mode, m_score, m_combo, m_max, m_idle, m_frames, m_pulse, m_over;
  logic [ND-1:0] m_prev;

  always @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = 0; m_score = 0; m_combo = 0; m_max = 0;
      m_idle = 0; m_frames = 0; m_pulse = 0; m_over = 0; m_prev = '0;
    end else begin
      int rises;
      rises = $countones(hit_in & ~m_prev);
      m_prev  = hit_in;
      m_pulse = 0;
      if (m_mode == 0) begin
        if (keycode == 8'h2c) begin
          m_mode = 1; m_score = 0; m_combo = 0; m_max = 0;
          m_idle = 0; m_frames = 0; m_prev = '0;
        end
      end else if (m_mode == 1) begin
        if (rises > 0) begin
          m_score += (m_combo >= 10) ? rises * 20 : rises * 10;
          if (m_score > SMAX) m_score = SMAX;
          m_combo += rises;
          if (m_combo > 255) m_combo = 255;
          if (m_combo > m_max) m_max = m_combo;
          m_idle  = 0;
          m_pulse = 1;
        end else begin
          m_idle++;
          if (m_idle == CW) begin
            m_combo = 0;
            m_idle  = 0;
          end
        end
        m_frames++;
        if (m_frames == GL) begin
          m_mode = 2;
          m_over = 1;
        end
      end else if (keycode == 8'h01) begin
        m_mode = 0;
        m_over = 0;
      end
    end
  end

  always @(negedge frame_clk) begin
    chk("cmp_score", int'(score), m_score);
    chk("cmp_combo", int'(combo), m_combo);
    chk("cmp_max_combo", int'(max_combo), m_max);
    chk("cmp_hit_pulse", int'(hit_pulse), m_pulse);
    chk("cmp_game_over", int'(game_over), m_over);
`ifdef SCORE_TALLY_BCD_EN
    chk("cmp_score_bcd", int'(score_bcd),
        ((m_score / 1000) % 10) * 4096 + ((m_score / 100) % 10) * 256 +
        ((m_score / 10) % 10) * 16 + (m_score % 10));
`endif
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse_hit(input logic [ND-1:0] bits);
    hit_in = bits;
    tick();
    hit_in = '0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!game_over && n < GL + 100) begin
      tick();
      n++;
    end
    chk(name, int'(game_over), 1);
  endtask

  initial begin
    Reset   = 1'b0;
    keycode = 8'h00;
    hit_in  = '0;
    #3;
    chk("reset_score", int'(score), 0);
    chk("reset_game_over", int'(game_over), 0);
    tick();
    tick();
    Reset = 1'b1;
    tick();

    // Hits while idle are ignored.
    pulse_hit(8'h40);
    chk("idle_hit_score", int'(score), 0);

    keycode = 8'h2c;
    tick();
    keycode = 8'h00;
    hit_in  = 8'h08;
    tick();
    chk("first_hit_score", int'(score), 10);
    chk("first_hit_combo", int'(combo), 1);
    chk("first_hit_max", int'(max_combo), 1);
    chk("first_hit_pulse", int'(hit_pulse), 1);
    tick();
    chk("held_level_pulse", int'(hit_pulse), 0);
    chk("held_level_score", int'(score), 10);
    hit_in = '0;
    tick();

    hit_in = 8'h21;
    tick();
    chk("double_hit_score", int'(score), 30);
    chk("double_hit_combo", int'(combo), 3);
    repeat (50) tick();
    chk("double_hold_score", int'(score), 30);
    chk("double_hold_combo", int'(combo), 3);
    hit_in = '0;
    tick();

    repeat (7) pulse_hit(8'h02);
    chk("combo10_score", int'(score), 100);
    chk("combo10_combo", int'(combo), 10);
    hit_in = 8'h02;
    tick();
    chk("bonus_hit_score", int'(score), 120);
    chk("bonus_hit_combo", int'(combo), 11);
    hit_in = '0;
    repeat (119) tick();
    chk("window_edge_combo", int'(combo), 11);
    tick();
    chk("window_clear_combo", int'(combo), 0);
    chk("window_keep_max", int'(max_combo), 11);

    for (int i = 0; i < 200 && m_score < SMAX; i++) pulse_hit(8'hFF);
    chk("sat_score", int'(score), 9999);
    chk("sat_combo", int'(combo), 255);
    chk("sat_max", int'(max_combo), 255);
`ifdef SCORE_TALLY_BCD_EN
    chk("sat_bcd", int'(score_bcd), 16'h9999);
`endif

    wait_done("game1_done");
    keycode = 8'h01;
    tick();
    keycode = 8'h00;
    tick();
    chk("back_idle_over", int'(game_over), 0);
    chk("back_idle_score", int'(score), 9999);
    keycode = 8'h2c;
    tick();
    keycode = 8'h00;
    chk("restart_score", int'(score), 0);
    chk("restart_max", int'(max_combo), 0);

    repeat (4) pulse_hit(8'h10);
    chk("pre_reset_score", int'(score), 40);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_combo", int'(combo), 0);
    chk("async_rst_max", int'(max_combo), 0);
    chk("async_rst_pulse", int'(hit_pulse), 0);
    chk("async_rst_over", int'(game_over), 0);
    tick();
    Reset = 1'b1;
    tick();

    keycode = 8'h2c;
    tick();
    keycode = 8'h00;
    pulse_hit(8'h80);
    chk("game3_score", int'(score), 10);
    wait_done("game3_done");
    hit_in = 8'h04;
    tick();
    chk("done_hit_score", int'(score), 10);
    chk("done_hit_pulse", int'(hit_pulse), 0);
    hit_in = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
